// File: rtl/divide_fp_pkg.sv
// divide_fp shared definitions
// Q15.8 format defaults, FSM states and saturation limits
package divide_fp_pkg;
  localparam int WIDTH = 24;
  localparam int FRAC  = 8;
  localparam int ITER  = WIDTH + FRAC;

  localparam logic [23:0] FP_MAX = 24'h7FFFFF;
  localparam logic [23:0] FP_MIN = 24'h800000;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;
endpackage

// File: rtl/fp_divide_core.sv
// fp_divide_core: unsigned restoring divider
// One quotient bit per step; o_last flags the final step
module fp_divide_core
  import divide_fp_pkg::*;
#(
  parameter int DW = ITER,
  parameter int VW = WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic          i_step,
  input  logic [DW-1:0] i_dividend,
  input  logic [VW-1:0] i_divisor,
  output logic [DW-1:0] o_quo,
  output logic          o_last
);
  localparam int CW = $clog2(DW + 1);

  logic [VW-1:0] r_div;
  logic [VW-1:0] r_rem;
  logic [DW-1:0] r_quo;
  logic [CW-1:0] r_cnt;

  logic [VW:0]   w_sh;
  logic [VW:0]   w_diff;
  logic          w_ge;

  assign w_sh   = {r_rem, r_quo[DW-1]};
  assign w_diff = w_sh - {1'b0, r_div};
  assign w_ge   = w_sh >= {1'b0, r_div};
  assign o_quo  = r_quo;
  assign o_last = r_cnt == CW'(1);

  // load operands, then shift/trial-subtract once per step
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div <= '0;
      r_rem <= '0;
      r_quo <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_div <= i_divisor;
      r_rem <= '0;
      r_quo <= i_dividend;
      r_cnt <= CW'(DW);
    end else if (i_step) begin
      r_rem <= w_ge ? w_diff[VW-1:0] : w_sh[VW-1:0];
      r_quo <= {r_quo[DW-2:0], w_ge};
      r_cnt <= r_cnt - CW'(1);
    end
  end
endmodule

// File: rtl/divide_fp.sv
// divide_fp: sequential signed Q15.8 divider
// Sign/zero handling and saturation around the unsigned core
module divide_fp #(
  parameter int WIDTH = divide_fp_pkg::WIDTH,
  parameter int FRAC  = divide_fp_pkg::FRAC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             div_zero,
  output logic             overflow
);
  import divide_fp_pkg::*;

  localparam int DW = WIDTH + FRAC;
  localparam logic [WIDTH-1:0] W_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] W_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  state_t r_state;
  state_t w_nxt;

  logic             r_sign;
  logic             r_aneg;
  logic             r_zero;
  logic [WIDTH-1:0] r_out;
  logic             r_done;
  logic             r_dz;
  logic             r_ov;

  logic             w_load;
  logic             w_step;
  logic             w_fix;
  logic             w_last;
  logic [WIDTH-1:0] w_amag;
  logic [WIDTH-1:0] w_bmag;
  logic [DW-1:0]    w_quo;
  logic [WIDTH-1:0] w_mag;
  logic             w_sat_pos;
  logic             w_sat_neg;
  logic [WIDTH-1:0] w_res;

  // magnitudes as unsigned so the most negative value survives
  assign w_amag = a[WIDTH-1] ? -a : a;
  assign w_bmag = b[WIDTH-1] ? -b : b;

  fp_divide_core #(
    .DW (DW),
    .VW (WIDTH)
  ) u_core (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_step     (w_step),
    .i_dividend ({w_amag, {FRAC{1'b0}}}),
    .i_divisor  (w_bmag),
    .o_quo      (w_quo),
    .o_last     (w_last)
  );

  assign w_mag     = w_quo[WIDTH-1:0];
  assign w_sat_pos = !r_sign && (w_quo > DW'(W_MAX));
  assign w_sat_neg = r_sign && (w_quo > DW'(W_MIN));
  assign w_res     = r_sign ? -w_mag : w_mag;

  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nxt;
  end

  // next state and datapath controls
  always_comb begin
    w_nxt  = r_state;
    w_load = 1'b0;
    w_step = 1'b0;
    w_fix  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_load = 1'b1;
          w_nxt  = (b == '0) ? FIX : RUN;
        end
      end
      RUN: begin
        w_step = 1'b1;
        if (w_last) w_nxt = FIX;
      end
      FIX: begin
        w_fix = 1'b1;
        w_nxt = IDLE;
      end
      default: w_nxt = IDLE;
    endcase
  end

  // capture sign information on acceptance
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sign <= 1'b0;
      r_aneg <= 1'b0;
      r_zero <= 1'b0;
    end else if (w_load) begin
      r_sign <= a[WIDTH-1] ^ b[WIDTH-1];
      r_aneg <= a[WIDTH-1];
      r_zero <= b == '0;
    end
  end

  // saturate, sign and register results; done pulses for one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out  <= '0;
      r_done <= 1'b0;
      r_dz   <= 1'b0;
      r_ov   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_fix) begin
        r_done <= 1'b1;
        if (r_zero) begin
          r_out <= r_aneg ? W_MIN : W_MAX;
          r_dz  <= 1'b1;
          r_ov  <= 1'b0;
        end else if (w_sat_pos) begin
          r_out <= W_MAX;
          r_dz  <= 1'b0;
          r_ov  <= 1'b1;
        end else if (w_sat_neg) begin
          r_out <= W_MIN;
          r_dz  <= 1'b0;
          r_ov  <= 1'b1;
        end else begin
          r_out <= w_res;
          r_dz  <= 1'b0;
          r_ov  <= 1'b0;
        end
      end
    end
  end

  assign busy     = r_state != IDLE;
  assign done     = r_done;
  assign out      = r_out;
  assign div_zero = r_dz;
  assign overflow = r_ov;
endmodule

// File: tb/tb_divide_fp.sv
// tb_divide_fp: directed checks for divide_fp
// Hand-computed quotients, latency, flags, reset and busy handling
module tb_divide_fp;
  import divide_fp_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [23:0] a;
  logic [23:0] b;
  logic        busy;
  logic        done;
  logic [23:0] out;
  logic        div_zero;
  logic        overflow;

  int n_chk;
  int n_fail;

  divide_fp dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .out      (out),
    .div_zero (div_zero),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input logic [23:0] ia,
                        input logic [23:0] ib,
                        input logic [23:0] eo,
                        input logic        edz,
                        input logic        eov);
    int cyc;
    bit got;
    @(negedge clk);
    a     = ia;
    b     = ib;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = 24'h0;
    b     = 24'h0;
    cyc   = 1;
    chk("busy_c1", busy, 1);
    got = 1'b0;
    while (!got && cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done) got = 1'b1;
    end
    chk("done_seen", got, 1);
    chk("latency", cyc, edz ? 2 : 34);
    chk("out", out, eo);
    chk("div_zero", div_zero, edz);
    chk("overflow", overflow, eov);
    chk("busy_done", busy, 0);
  endtask

  logic [23:0] va  [10];
  logic [23:0] vb  [10];
  logic [23:0] vo  [10];
  logic        vdz [10];
  logic        vov [10];

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    start  = 1'b0;
    a      = 24'h0;
    b      = 24'h0;

    va[0] = 24'h000300; vb[0] = 24'h000200; vo[0] = 24'h000180;
    va[1] = 24'h000300; vb[1] = 24'h000180; vo[1] = 24'h000200;
    va[2] = 24'hFFFD00; vb[2] = 24'h000200; vo[2] = 24'hFFFE80;
    va[3] = 24'h000100; vb[3] = 24'h000300; vo[3] = 24'h000055;
    va[4] = 24'hFFFF00; vb[4] = 24'h000300; vo[4] = 24'hFFFFAB;
    va[5] = 24'h000100; vb[5] = 24'h000000; vo[5] = FP_MAX;
    va[6] = 24'hFFFF00; vb[6] = 24'h000000; vo[6] = FP_MIN;
    va[7] = 24'hFFFF00; vb[7] = 24'hFFFE00; vo[7] = 24'h000080;
    va[8] = 24'h800000; vb[8] = 24'hFFFFFF; vo[8] = FP_MAX;
    va[9] = 24'h7FFFFF; vb[9] = 24'h000001; vo[9] = FP_MAX;
    for (int i = 0; i < 10; i++) begin
      vdz[i] = (i == 5) || (i == 6);
      vov[i] = (i == 8) || (i == 9);
    end

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out", out, 0);
    chk("rst_dz", div_zero, 0);
    chk("rst_ov", overflow, 0);

    for (int i = 0; i < 10; i++)
      run_op(va[i], vb[i], vo[i], vdz[i], vov[i]);

    // abort: start at C, rst sampled at C+10
    begin
      int nd;
      @(negedge clk);
      a     = 24'h000300;
      b     = 24'h000200;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      start = 1'b1;
      rst   = 1'b1;
      @(posedge clk);
      #1;
      rst   = 1'b0;
      start = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_out", out, 0);
      chk("abort_ov", overflow, 0);
      nd = 0;
      for (int k = 0; k < 40; k++) begin
        @(posedge clk);
        #1;
        if (done) nd++;
        if (busy) nd++;
      end
      chk("abort_no_done", nd, 0);
    end

    // start re-asserted while busy must be ignored
    begin
      int cyc;
      int nd;
      int dcyc;
      logic [23:0] dout;
      @(negedge clk);
      a     = 24'h000300;
      b     = 24'h000200;
      start = 1'b1;
      @(posedge clk);
      #1;
      a    = 24'h000100;
      b    = 24'h000300;
      cyc  = 1;
      nd   = 0;
      dcyc = 0;
      dout = 24'h0;
      while (cyc < 70) begin
        @(posedge clk);
        #1;
        cyc++;
        if (cyc == 20) start = 1'b0;
        if (done) begin
          nd++;
          if (nd == 1) begin
            dcyc = cyc;
            dout = out;
          end
        end
      end
      chk("ign_ndone", nd, 1);
      chk("ign_lat", dcyc, 34);
      chk("ign_out", dout, 24'h000180);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/divide_fp.md
# divide_fp

Sequential signed fixed-point divider for the Mode7 affine pipeline; the inverse operation of the combinational `multiply_fp`, in the same 24-bit Q15.8 format. It computes `out = a / b` over 32 cycles of restoring division on magnitudes. Scanline setup uses it to derive per-line scale and step values, such as the reciprocal of depth, which then feed the multiply stages.

## Interface
Parameters:
- `WIDTH`, 24: total word width, two's-complement.
- `FRAC`, 8: fractional bits.

Ports:
- `clk`, input, 1: sole clock, rising edge.
- `rst`, input, 1: synchronous reset, active-high.
- `start`, input, 1: request. It is sampled only while idle.
- `a`, input, WIDTH: dividend, Q15.8. Captured on an accepted `start`.
- `b`, input, WIDTH: divisor, Q15.8. Captured on an accepted `start`.
- `busy`, output, 1: high from the cycle after acceptance until `done`.
- `done`, output, 1: one-cycle pulse; `out` and the flags are valid from this cycle.
- `out`, output, WIDTH: quotient, Q15.8. Held until the next `done`.
- `div_zero`, output, 1: the last operation had `b == 0`.
- `overflow`, output, 1: the last quotient saturated.

## Operation
- Reset values: `busy=0`, `done=0`, `out=0`, `div_zero=0`, `overflow=0`. The FSM goes to `IDLE`.
- FSM states: `IDLE`, `RUN`, `FIX`.
  - `IDLE` with `start=1`: latch the sign (`a[msb]^b[msb]`) and the magnitudes `|a|` and `|b|`, each as a 24-bit unsigned value so that −2^23 is representable.
  - Dividend register = `|a| << FRAC`, 32 bits. Iteration counter = 32.
  - If `b == 0`, go to `FIX` with `div_zero` pending. Otherwise go to `RUN`.
- `RUN`: one restoring step per cycle.
  - Shift the remainder/quotient pair left by 1.
  - Trial-subtract `|b|`. If the result is non-negative, keep it and set quotient bit = 1.
  - Decrement the counter. When the counter reaches 0, go to `FIX`.
- `FIX`: saturate, apply the sign, register the outputs, pulse `done`, return to `IDLE`.
  - Positive result: if the magnitude exceeds 0x7FFFFF, output 0x7FFFFF with `overflow=1`.
  - Negative result: if the magnitude exceeds 0x800000, output 0x800000 with `overflow=1`.
  - Otherwise output the magnitude with its two's-complement sign applied.
  - Divide-by-zero: output 0x7FFFFF if `a>=0`, 0x800000 if `a<0`; `div_zero=1`, `overflow=0`.
- Rounding: truncation toward zero. The remainder is discarded.
- `start` while `busy` is ignored; no queueing.
- `start` in the same cycle `done` is high is accepted, because the FSM is already in `IDLE`.
- `div_zero` and `overflow` update only at `done` and hold until the next `done`.

## Timing
Cycle C is the rising edge that samples `start=1` in `IDLE`.
- Normal division: `busy` is high for cycles C+1 through C+33. The 32 `RUN` cycles span C+1..C+32 and `FIX` is C+33. `done` is high in C+34 with `busy=0`. Latency is 34 cycles.
- Divide-by-zero: `busy` is high in C+1 (`FIX`) and `done` is high in C+2.
- Throughput: one operation per 34 cycles, back-to-back if `start` is held.
- `rst` during `RUN` or `FIX`:
  - All outputs return to their reset values on the next edge.
  - No `done` is issued for the aborted operation.
  - A `start` sampled in the same cycle as `rst` is dropped.
- `a` and `b` may change freely after cycle C.

## Structure
- Package `divide_fp_pkg` holds:
  - `WIDTH` and `FRAC` defaults;
  - the state enum (`IDLE`, `RUN`, `FIX`);
  - the saturation constants `FP_MAX=24'h7FFFFF` and `FP_MIN=24'h800000`;
  - the iteration count `WIDTH+FRAC`.
- One sub-module, `fp_divide_core`: an unsigned iterative restoring loop (load / step / finished). `divide_fp` wraps it with sign handling, zero detection, saturation and the output registers.

## Test plan
- a=0x000300 (3.0), b=0x000200 (2.0) -> `out`=0x000180 (1.5). `done` exactly 34 cycles after C. Both flags 0.
- a=0x000300, b=0x000180 -> `out`=0x000200 (inverse check against `multiply_fp`). a=0xFFFD00 (−3.0), b=0x000200 -> `out`=0xFFFE80 (−1.5).
- a=0x000100, b=0x000300 -> `out`=0x000055 (truncation). a=0xFFFF00, b=0x000300 -> `out`=0xFFFFAB (truncation toward zero).
- a=0x000100, b=0 -> `out`=0x7FFFFF, `div_zero`=1, `done` at C+2. a=0xFFFF00, b=0 -> `out`=0x800000.
- a=0x7FFFFF, b=0x000001 -> `out`=0x7FFFFF, `overflow`=1. a=0x800000, b=0xFFFFFF -> `out`=0x7FFFFF, `overflow`=1.
- Reset and busy handling:
  - `start` at C, pulse `rst` at C+10 -> `busy`=0 at C+11, no `done` within 40 cycles, `out`=0.
  - `start` re-asserted during `busy` -> ignored; exactly one `done`, carrying the original operands' result.
